// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 receive path and the
//            downstream scancode assembler.
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Receive frame FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Scancode prefixes shared with the keyboard assembler
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with extra-MSB pointers. Head is read
//            combinationally from registered state. A push while full is
//            accepted only when a pop frees the slot in the same cycle.
//            DEPTH must be a power of two, at least 2.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_o  = mem_q[rp_q[AW-1:0]];

  // Pops on empty are ignored; a pop makes room for a same-cycle push when full
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer next-state
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  // Pointer and storage registers; storage cleared so head reads 0 after reset
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver. Synchronises the raw pins,
//            deserialises 11-bit frames, checks start/stop/odd parity and
//            queues good bytes in a FIFO popped by an active-low request.
// Revision : 1.0  initial release
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  output logic       frame_err
);

  localparam int LAST  = SYNC_STAGES - 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   ps2_fall;
  logic                   ps2_din;

  rx_state_t              state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic                   stop_q, stop_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   overflow_q, overflow_d;

  logic                   tmo_expired;
  logic                   frame_good;
  logic                   push;
  logic                   pop_req;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Pin synchronisers; bit 0 is the newest sample, idle line level is 1
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign ps2_fall = !clk_sync_q[LAST-1] && clk_sync_q[LAST];
  assign ps2_din  = data_sync_q[LAST];

  // A partial frame is abandoned after a long gap between PS/2 clock edges
  assign tmo_expired = (state_q == SHIFT) && !ps2_fall &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // shift_q[0]=start, shift_q[8:1]=D0..D7, shift_q[9]=parity
  assign frame_good = !shift_q[0] && stop_q && (^shift_q[9:1]);

  // Frame FSM state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_q     <= 1'b0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      stop_q     <= stop_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame FSM next-state: shift bits on falling edges, watch for timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    tmo_d     = '0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (ps2_fall && !ps2_din) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd1;
          shift_d   = {ps2_din, shift_q[9:1]};
        end
      end
      SHIFT: begin
        if (ps2_fall) begin
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            stop_d  = ps2_din;
            state_d = CHECK;
          end else begin
            shift_d   = {ps2_din, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_expired) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Frame FSM outputs: push good bytes, flag bad frames and timeouts
  always_comb begin
    push      = (state_q == CHECK) && frame_good;
    frame_err = ((state_q == CHECK) && !frame_good) || tmo_expired;
  end

  assign pop_req = !nextdata_n;

  // Overflow is sticky; a full-FIFO push is only lost if no pop frees a slot
  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !(pop_req && !fifo_empty)) overflow_d = 1'b1;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push),
    .wdata_i (shift_q[8:1]),
    .pop_i   (pop_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (data)
  );

  assign ready    = !fifo_empty;
  assign overflow = overflow_q;

endmodule : ps2_rx_fifo
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Directed self-checking bench for ps2_rx_fifo. PS/2 clock is
//            scaled to 40 system clocks per bit and the timeout shortened.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int HALF = 20;
  localparam int SYNC = 3;
  localparam int TMO  = 300;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;

  ps2_rx_fifo #(
    .DEPTH          (8),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .ready      (ready),
    .nextdata_n (nextdata_n),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count cycles with frame_err high, sampled away from the active edge
  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic [10:0] f;
    f = frame_bits(d, bad_par);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    tick(HALF);
  endtask

  // Last falling edge timed so nextdata_n is low exactly during the CHECK cycle
  task automatic send_frame_pop(input logic [7:0] d);
    logic [10:0] f;
    f = frame_bits(d, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    tick(HALF);
    ps2_clk = 1'b0;
    tick(SYNC);
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    tick(HALF - SYNC - 1);
    ps2_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    tick(2);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected %h", data, 8'h00); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected %b", ready, 1'b0); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected %b", overflow, 1'b0); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected %b", frame_err, 1'b0); end
    clrn = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_latency();
    logic [10:0] f;
    int e0;
    e0 = err_pulses;
    f = frame_bits(8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    tick(HALF);
    ps2_clk = 1'b0;
    tick(SYNC);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL clean_ready_in_check: got %b expected %b", ready, 1'b0); end
    tick(1);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL clean_ready_after_check: got %b expected %b", ready, 1'b1); end
    checks++; if (data !== 8'h1C) begin failures++; $display("FAIL clean_data: got %h expected %h", data, 8'h1C); end
    tick(HALF - SYNC - 1);
    ps2_clk = 1'b1;
    tick(HALF);
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL clean_no_err: got %0d expected %0d", err_pulses, e0); end
    pop_one();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL clean_ready_after_pop: got %b expected %b", ready, 1'b0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = SC_EXTEND;
    exp[1] = SC_BREAK;
    exp[2] = 8'h75;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, ready, 1'b1); end
      checks++; if (data !== exp[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, data, exp[i]); end
      pop_one();
    end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %b expected %b", ready, 1'b0); end
  endtask

  task automatic test_parity_error();
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL parity_err_pulse: got %0d expected %0d", err_pulses, e0 + 1); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL parity_no_push: got %b expected %b", ready, 1'b0); end
  endtask

  task automatic test_full_pop_same_cycle();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
    checks++; if (data !== 8'h01) begin failures++; $display("FAIL fullpop_head: got %h expected %h", data, 8'h01); end
    send_frame_pop(8'h09);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow: got %b expected %b", overflow, 1'b0); end
    for (int i = 2; i <= 9; i++) begin
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fullpop_ready[%0d]: got %b expected %b", i, ready, 1'b1); end
      checks++; if (data !== 8'(i)) begin failures++; $display("FAIL fullpop_data[%0d]: got %h expected %h", i, data, 8'(i)); end
      pop_one();
    end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fullpop_empty: got %b expected %b", ready, 1'b0); end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int e0;
    e0 = err_pulses;
    f = frame_bits(8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    tick(200);
    checks++; if (err_pulses !== e0) begin failures++; $display("FAIL tmo_early: got %0d expected %0d", err_pulses, e0); end
    tick(150);
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL tmo_pulse: got %0d expected %0d", err_pulses, e0 + 1); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL tmo_no_push: got %b expected %b", ready, 1'b0); end
    send_frame(8'h5A, 1'b0);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL tmo_next_ready: got %b expected %b", ready, 1'b1); end
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL tmo_next_data: got %h expected %h", data, 8'h5A); end
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL tmo_next_no_err: got %0d expected %0d", err_pulses, e0 + 1); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full: got %b expected %b", overflow, 1'b0); end
    send_frame(8'h09, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected %b", overflow, 1'b1); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (data !== 8'(i)) begin failures++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, data, 8'(i)); end
      pop_one();
    end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %b expected %b", ready, 1'b0); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected %b", overflow, 1'b1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL rst_pre_data: got %h expected %h", data, 8'h11); end
    f = frame_bits(8'h44, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(f[i]);
    clrn = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %b expected %b", ready, 1'b0); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_overflow: got %b expected %b", overflow, 1'b0); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %h expected %h", data, 8'h00); end
    tick(1);
    clrn = 1'b1;
    tick(2);
    send_frame(8'h3C, 1'b0);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_next_ready: got %b expected %b", ready, 1'b1); end
    checks++; if (data !== 8'h3C) begin failures++; $display("FAIL rst_next_data: got %h expected %h", data, 8'h3C); end
    pop_one();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_next_empty: got %b expected %b", ready, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_clean_latency();
    test_back_to_back();
    test_parity_error();
    test_full_pop_same_cycle();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ps2_rx_fifo
`default_nettype wire
